// File: rtl/disp_pkg.sv
// rtl/disp_pkg.sv - shared types and constants for the display VRAM path
package disp_pkg;

    // Fetch FSM states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAITBUF = 2'd1,
        ST_AREQ    = 2'd2,
        ST_RBEAT   = 2'd3
    } disp_state_t;

    // 4-byte beats, incrementing bursts
    localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
    localparam logic [1:0] AXI_BURST_INCR = 2'b01;

    localparam int DEF_H_PIX     = 640;
    localparam int DEF_V_PIX     = 480;
    localparam int DEF_BURST_LEN = 16;
    localparam int BYTES_PER_PIX = 4;

    // Counter width for n distinct values, never below one bit
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/disp_vsync_det.sv
// rtl/disp_vsync_det.sv - VSYNC synchronizer with registered falling-edge pulse
module disp_vsync_det (
    input  logic ACLK,
    input  logic ARST_X,
    input  logic VSYNC_X,
    output logic VS_FALL
);

    logic sync1;
    logic sync2;
    logic sync_d;

    // Two-flop synchronizer, delay flop, then a one-cycle pulse on 1->0
    always_ff @(posedge ACLK) begin
        if (!ARST_X) begin
            sync1   <= 1'b1;
            sync2   <= 1'b1;
            sync_d  <= 1'b1;
            VS_FALL <= 1'b0;
        end else begin
            sync1   <= VSYNC_X;
            sync2   <= sync1;
            sync_d  <= sync2;
            VS_FALL <= sync_d & ~sync2;
        end
    end

endmodule

// File: rtl/disp_vramctrl.sv
// rtl/disp_vramctrl.sv - frame-based AXI4 read master feeding the display pixel FIFO
module disp_vramctrl
    import disp_pkg::*;
#(
    parameter int H_PIX     = DEF_H_PIX,
    parameter int V_PIX     = DEF_V_PIX,
    parameter int BURST_LEN = DEF_BURST_LEN
) (
    input  logic        ACLK,
    input  logic        ARST_X,
    input  logic        DSP_VSYNC_X,
    input  logic        DISPON,
    input  logic [28:0] DISPADDR,
    output logic [31:0] ARADDR,
    output logic [7:0]  ARLEN,
    output logic [2:0]  ARSIZE,
    output logic [1:0]  ARBURST,
    output logic        ARVALID,
    input  logic        ARREADY,
    input  logic [31:0] RDATA,
    input  logic        RVALID,
    input  logic        RLAST,
    output logic        RREADY,
    input  logic        BUF_ROOM,
    output logic        BUF_WREN,
    output logic [31:0] BUF_WDATA,
    output logic        FRAME_BUSY,
    output logic        FRAME_OVR
);

    localparam int N_BURST = (H_PIX * V_PIX) / BURST_LEN;
    localparam int BCNT_W  = cnt_width(N_BURST);
    localparam logic [BCNT_W-1:0] LAST_BURST  = BCNT_W'(N_BURST - 1);
    localparam logic [28:0]       BURST_BYTES = 29'(BURST_LEN * BYTES_PER_PIX);
    // Base is forced to 64-byte alignment so no burst straddles a 4 KB page
    localparam logic [28:0]       BASE_MASK   = 29'h1FFF_FFC0;

    disp_state_t       state;
    disp_state_t       state_nxt;
    logic              vs_fall;
    logic [28:0]       base;
    logic [BCNT_W-1:0] burst_cnt;
    logic [28:0]       ar_addr_q;
    logic              frame_start;
    logic              r_beat;
    logic              last_burst;

    disp_vsync_det u_vsync_det (
        .ACLK    (ACLK),
        .ARST_X  (ARST_X),
        .VSYNC_X (DSP_VSYNC_X),
        .VS_FALL (vs_fall)
    );

    assign ARLEN       = 8'(BURST_LEN - 1);
    assign ARSIZE      = AXI_SIZE_4B;
    assign ARBURST     = AXI_BURST_INCR;
    assign ARADDR      = {3'b000, ar_addr_q};

    assign frame_start = (state == ST_IDLE) && vs_fall && DISPON;
    assign r_beat      = RVALID && RREADY;
    assign last_burst  = (burst_cnt == LAST_BURST);

    // State register
    always_ff @(posedge ACLK) begin
        if (!ARST_X) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic; a burst always runs to RLAST before DISPON is honoured
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (vs_fall && DISPON) begin
                    state_nxt = ST_WAITBUF;
                end
            end
            ST_WAITBUF: begin
                if (BUF_ROOM) begin
                    state_nxt = ST_AREQ;
                end
            end
            ST_AREQ: begin
                if (ARREADY) begin
                    state_nxt = ST_RBEAT;
                end
            end
            ST_RBEAT: begin
                if (RVALID && RLAST) begin
                    state_nxt = (last_burst || !DISPON) ? ST_IDLE : ST_WAITBUF;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Moore outputs decoded from the state
    always_comb begin
        ARVALID    = 1'b0;
        RREADY     = 1'b0;
        FRAME_BUSY = 1'b0;
        case (state)
            ST_WAITBUF: FRAME_BUSY = 1'b1;
            ST_AREQ: begin
                ARVALID    = 1'b1;
                FRAME_BUSY = 1'b1;
            end
            ST_RBEAT: begin
                RREADY     = 1'b1;
                FRAME_BUSY = 1'b1;
            end
            default: ;
        endcase
    end

    // Frame base shadow and burst counter
    always_ff @(posedge ACLK) begin
        if (!ARST_X) begin
            base      <= '0;
            burst_cnt <= '0;
        end else if (frame_start) begin
            base      <= DISPADDR & BASE_MASK;
            burst_cnt <= '0;
        end else if ((state == ST_RBEAT) && RVALID && RLAST) begin
            burst_cnt <= burst_cnt + 1'b1;
        end
    end

    // Burst address is computed on the way into AREQ and held until ARREADY
    always_ff @(posedge ACLK) begin
        if (!ARST_X) begin
            ar_addr_q <= '0;
        end else if ((state == ST_WAITBUF) && BUF_ROOM) begin
            ar_addr_q <= base + 29'(burst_cnt) * BURST_BYTES;
        end
    end

    // Registered FIFO write: one strobe per accepted R beat
    always_ff @(posedge ACLK) begin
        if (!ARST_X) begin
            BUF_WREN  <= 1'b0;
            BUF_WDATA <= '0;
        end else begin
            BUF_WREN <= r_beat;
            if (r_beat) begin
                BUF_WDATA <= RDATA;
            end
        end
    end

    // Frame start seen while a fetch is still running
    always_ff @(posedge ACLK) begin
        if (!ARST_X) begin
            FRAME_OVR <= 1'b0;
        end else begin
            FRAME_OVR <= vs_fall && (state != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_disp_vramctrl.sv
// tb/tb_disp_vramctrl.sv - scoreboard bench for disp_vramctrl
module tb_disp_vramctrl;

    localparam int H  = 32;
    localparam int V  = 16;
    localparam int BL = 16;
    localparam int NB = H * V / BL;
    localparam int NPIX = H * V;
    localparam int TMO = 8000;

    logic        ACLK = 1'b0;
    logic        ARST_X = 1'b0;
    logic        DSP_VSYNC_X = 1'b1;
    logic        DISPON = 1'b0;
    logic [28:0] DISPADDR = '0;
    logic [31:0] ARADDR;
    logic [7:0]  ARLEN;
    logic [2:0]  ARSIZE;
    logic [1:0]  ARBURST;
    logic        ARVALID;
    logic        ARREADY = 1'b0;
    logic [31:0] RDATA = '0;
    logic        RVALID = 1'b0;
    logic        RLAST = 1'b0;
    logic        RREADY;
    logic        BUF_ROOM = 1'b1;
    logic        BUF_WREN;
    logic [31:0] BUF_WDATA;
    logic        FRAME_BUSY;
    logic        FRAME_OVR;

    disp_vramctrl #(.H_PIX(H), .V_PIX(V), .BURST_LEN(BL)) dut (
        .ACLK(ACLK), .ARST_X(ARST_X), .DSP_VSYNC_X(DSP_VSYNC_X),
        .DISPON(DISPON), .DISPADDR(DISPADDR),
        .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
        .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RVALID(RVALID), .RLAST(RLAST), .RREADY(RREADY),
        .BUF_ROOM(BUF_ROOM), .BUF_WREN(BUF_WREN), .BUF_WDATA(BUF_WDATA),
        .FRAME_BUSY(FRAME_BUSY), .FRAME_OVR(FRAME_OVR)
    );

    always #5 ACLK = ~ACLK;

    int checks = 0;
    int failures = 0;

    logic [31:0] ar_q[$];
    logic [31:0] pix_q[$];
    logic [31:0] bq[$];
    int ar_hs_cnt = 0;
    int pix_popped = 0;
    int ovr_cnt = 0;

    logic fast = 1'b0;
    logic ar_hold = 1'b0;
    logic room_rand = 1'b0;
    logic room_force = 1'b1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // AXI slave memory: one beat of data per word address
    int beat = 0;
    logic s_rst, s_ar_hs, s_r_hs;
    logic [31:0] s_araddr;
    always begin
        @(negedge ACLK);
        s_rst    = !ARST_X;
        s_ar_hs  = ARVALID && ARREADY;
        s_r_hs   = RVALID && RREADY;
        s_araddr = ARADDR;
        @(posedge ACLK);
        #1;
        if (s_rst) begin
            bq.delete();
            beat = 0;
            ARREADY = 1'b0;
            RVALID = 1'b0;
            RLAST = 1'b0;
        end else begin
            if (s_ar_hs) begin
                chk("one_outstanding", bq.size(), 0);
                bq.push_back(s_araddr);
            end
            if (s_r_hs) begin
                if (RLAST) begin
                    void'(bq.pop_front());
                    beat = 0;
                end else begin
                    beat++;
                end
            end
            ARREADY = ar_hold ? 1'b0 : (fast ? 1'b1 : ($urandom_range(3) != 0));
            if (RVALID && !s_r_hs) begin
                // hold the pending beat
            end else if (bq.size() > 0 && (fast || $urandom_range(3) != 0)) begin
                RVALID = 1'b1;
                RDATA  = mem_word(bq[0] + 32'(4 * beat));
                RLAST  = (beat == BL - 1);
            end else begin
                RVALID = 1'b0;
                RLAST  = 1'b0;
            end
        end
    end

    always begin
        @(posedge ACLK);
        #1;
        BUF_ROOM = room_rand ? ($urandom_range(2) != 0) : room_force;
    end

    // Monitor: compare AR addresses and FIFO writes against the scoreboard
    always @(negedge ACLK) begin
        if (ARST_X) begin
            if (ARVALID && ARREADY) begin
                ar_hs_cnt++;
                if (ar_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL ar_unexpected addr=%h required=no_request", ARADDR);
                end else begin
                    chk("araddr", ARADDR, ar_q.pop_front());
                end
            end
            if (BUF_WREN) begin
                pix_popped++;
                if (pix_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL wr_unexpected data=%h required=no_write", BUF_WDATA);
                end else begin
                    chk("pixel", BUF_WDATA, pix_q.pop_front());
                end
            end
            if (FRAME_OVR) ovr_cnt++;
        end
    end

    // Reference model: one frame is NPIX words from the aligned base, in order
    task automatic expect_frame(input logic [28:0] addr);
        logic [28:0] b;
        logic [28:0] a;
        b = {addr[28:6], 6'b0};
        for (int k = 0; k < NB; k++) begin
            a = b + 29'(k * BL * 4);
            ar_q.push_back({3'b000, a});
        end
        for (int p = 0; p < NPIX; p++) begin
            a = b + 29'(p * 4);
            pix_q.push_back(mem_word({3'b000, a}));
        end
    endtask

    task automatic pulse_vsync();
        @(posedge ACLK);
        #1;
        DSP_VSYNC_X = 1'b0;
        repeat (4) @(posedge ACLK);
        #1;
        DSP_VSYNC_X = 1'b1;
    endtask

    task automatic start_frame(input logic [28:0] addr);
        @(posedge ACLK);
        #1;
        DISPON = 1'b1;
        DISPADDR = addr;
        ar_hs_cnt = 0;
        pix_popped = 0;
        ovr_cnt = 0;
        expect_frame(addr);
        pulse_vsync();
    endtask

    task automatic wait_done(input int exp_ovr);
        int cyc;
        cyc = 0;
        while ((ar_q.size() != 0 || pix_q.size() != 0) && cyc < TMO) begin
            @(negedge ACLK);
            cyc++;
        end
        if (cyc >= TMO) begin
            checks++;
            failures++;
            $display("FAIL frame_timeout ar_left=%0d pix_left=%0d required=0", ar_q.size(), pix_q.size());
            ar_q.delete();
            pix_q.delete();
        end
        @(negedge ACLK);
        chk("busy_end", FRAME_BUSY, 0);
        repeat (5) @(negedge ACLK);
        chk("arvalid_idle", ARVALID, 0);
        chk("ovr_count", ovr_cnt, exp_ovr);
    endtask

    task automatic wait_posedge_until_ar(input int n);
        int cyc;
        cyc = 0;
        while (ar_hs_cnt < n && cyc < TMO) begin
            @(posedge ACLK);
            #1;
            cyc++;
        end
        if (cyc >= TMO) begin
            checks++;
            failures++;
            $display("FAIL ar_wait_timeout seen=%0d required=%0d", ar_hs_cnt, n);
        end
    endtask

    initial begin
        int bad;
        int keep;
        int cyc;

        // Reset state
        repeat (4) @(posedge ACLK);
        @(negedge ACLK);
        chk("rst_arvalid", ARVALID, 0);
        chk("rst_rready", RREADY, 0);
        chk("rst_wren", BUF_WREN, 0);
        chk("rst_busy", FRAME_BUSY, 0);
        chk("rst_ovr", FRAME_OVR, 0);
        chk("rst_araddr", ARADDR, 0);
        chk("rst_wdata", BUF_WDATA, 0);
        chk("arlen", ARLEN, BL - 1);
        chk("arsize", ARSIZE, 3'b010);
        chk("arburst", ARBURST, 2'b01);
        @(posedge ACLK);
        #1;
        ARST_X = 1'b1;
        repeat (5) @(negedge ACLK);
        chk("no_false_fall", FRAME_BUSY, 0);

        // Basic frame, always-ready slave
        fast = 1'b1;
        start_frame(29'h0010_0000);
        wait_done(0);

        // Unaligned base, random slave and FIFO room
        fast = 1'b0;
        room_rand = 1'b1;
        start_frame(29'h0000_0047);
        wait_done(0);

        // Back-pressure after burst 3
        room_rand = 1'b0;
        room_force = 1'b1;
        start_frame(29'h0123_4580);
        wait_posedge_until_ar(4);
        room_force = 1'b0;
        @(posedge ACLK);
        bad = 0;
        repeat (50) begin
            @(negedge ACLK);
            if (ARVALID) bad++;
        end
        chk("bp_arvalid_low", bad, 0);
        @(posedge ACLK);
        #1;
        room_force = 1'b1;
        wait_done(0);

        // DISPON drop in the middle of burst 10
        start_frame(29'h0040_0000);
        cyc = 0;
        while (pix_popped < 10 * BL + 2 && cyc < TMO) begin
            @(posedge ACLK);
            #1;
            cyc++;
        end
        DISPON = 1'b0;
        ar_q.delete();
        keep = 11 * BL - pix_popped;
        while (pix_q.size() > keep) void'(pix_q.pop_back());
        wait_done(0);
        chk("drop_beats", pix_popped, 11 * BL);
        chk("drop_ars", ar_hs_cnt, 11);

        // VSYNC with display off does nothing
        ar_hs_cnt = 0;
        pulse_vsync();
        repeat (10) @(negedge ACLK);
        chk("off_idle", FRAME_BUSY, 0);
        chk("off_no_ar", ar_hs_cnt, 0);

        // Overrun plus mid-frame DISPADDR write, then the next frame uses it
        room_rand = 1'b1;
        start_frame(29'h0020_0000);
        wait_posedge_until_ar(5);
        DISPADDR = 29'h0030_0100;
        pulse_vsync();
        wait_done(1);
        start_frame(29'h0030_0100);
        wait_done(0);

        // Reset while ARVALID is waiting for ARREADY
        room_rand = 1'b0;
        start_frame(29'h0050_0000);
        wait_posedge_until_ar(3);
        ar_hold = 1'b1;
        repeat (2) @(posedge ACLK);
        cyc = 0;
        do begin
            @(negedge ACLK);
            cyc++;
        end while (!ARVALID && cyc < TMO);
        chk("areq_reached", ARVALID, 1);
        @(posedge ACLK);
        #1;
        ARST_X = 1'b0;
        @(posedge ACLK);
        @(negedge ACLK);
        chk("rst_mid_arvalid", ARVALID, 0);
        chk("rst_mid_busy", FRAME_BUSY, 0);
        chk("rst_mid_rready", RREADY, 0);
        ar_q.delete();
        pix_q.delete();
        repeat (3) @(posedge ACLK);
        #1;
        ar_hold = 1'b0;
        ARST_X = 1'b1;
        start_frame(29'h0060_0000);
        wait_done(0);

        // Random frames, including a base that wraps past 2^29
        room_rand = 1'b1;
        start_frame(29'h1FFF_FE47);
        wait_done(0);
        for (int n = 0; n < 2; n++) begin
            start_frame(29'($urandom));
            wait_done(0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
